// File: rtl/ram_1p_dma_if.sv
// ============================================================================
// Module   : ram_1p_dma_if
// Purpose  : Single-port 32-bit RAM request bus (req/we/be/addr/wdata, rvalid/rdata).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_1p_dma_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/ram_1p_dma.sv
// ============================================================================
// Module   : ram_1p_dma
// Purpose  : Word-granular block copy / block fill engine driving a 1-port RAM.
//            Optional running checksum of written data: RAM_1P_DMA_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_1p_dma #(
  parameter int unsigned LenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LenWidth-1:0] len_i,
  input  logic [31:0]         fill_data_i,
  output logic                busy_o,
  output logic                done_o,
`ifdef RAM_1P_DMA_CHECKSUM_EN
  output logic [31:0]         checksum_o,
`endif
  ram_1p_dma_if.master        mem
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [29:0]         src_q, src_d;
  logic [29:0]         dst_q, dst_d;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic [31:0]         fill_q, fill_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [29:0]         addr_q, addr_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_acc;

  // Byte-offset bits of the command addresses carry no meaning for word transfers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  assign start_acc = (state_q == S_IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d = mode_i;
          src_d  = src_addr_i[31:2];
          dst_d  = dst_addr_i[31:2];
          cnt_d  = len_i;
          fill_d = fill_data_i;
          if (len_i == '0) begin
            state_d = S_DONE;
          end else if (mode_i) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem.rvalid) begin
          wdata_d = mem.rdata;
          state_d = S_WR;
        end
      end
      S_WR: begin
        cnt_d = cnt_q - LenWidth'(1);
        dst_d = dst_q + 30'd1;
        if (!mode_q) begin
          src_d = src_q + 30'd1;
        end
        if (cnt_q == LenWidth'(1)) begin
          state_d = S_DONE;
        end else if (mode_q) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Memory-side outputs are registered, so they are derived from the state being entered.
    if ((state_d == S_WR) && mode_d) begin
      wdata_d = fill_d;
    end

    addr_d = addr_q;
    if (state_d == S_RD) begin
      addr_d = src_d;
    end else if (state_d == S_WR) begin
      addr_d = dst_d;
    end

    req_d  = (state_d == S_RD) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    busy_d = (state_d == S_RD) || (state_d == S_WAIT) || (state_d == S_WR);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef RAM_1P_DMA_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Folds in exactly the word presented on the bus during each write cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      checksum_q <= '0;
    end else if (start_acc) begin
      checksum_q <= '0;
    end else if (state_q == S_WR) begin
      checksum_q <= {checksum_q[30:0], checksum_q[31]} ^ wdata_q;
    end
  end

  assign checksum_o = checksum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.be    = 4'hF;
  assign mem.addr  = {addr_q, 2'b00};
  assign mem.wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_1p_dma.sv
// ============================================================================
// Module   : tb_ram_1p_dma
// Purpose  : Scoreboard bench for ram_1p_dma with a RAM responder and a word-level
//            reference model. Checksum checks active with RAM_1P_DMA_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_1p_dma;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [31:0]   src = '0;
  logic [31:0]   dst = '0;
  logic [LW-1:0] len = '0;
  logic [31:0]   fill = '0;
  logic          busy;
  logic          done;
`ifdef RAM_1P_DMA_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  ram_1p_dma_if mem_bus ();

  ram_1p_dma #(.LenWidth(LW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .src_addr_i  (src),
    .dst_addr_i  (dst),
    .len_i       (len),
    .fill_data_i (fill),
    .busy_o      (busy),
    .done_o      (done),
`ifdef RAM_1P_DMA_CHECKSUM_EN
    .checksum_o  (checksum),
`endif
    .mem         (mem_bus.master)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // RAM responder: accepts every request, read data one cycle later.
  logic [31:0] ram  [bit [29:0]];
  logic [31:0] refm [bit [29:0]];

  function automatic logic [31:0] ram_rd(bit [29:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(bit [29:0] a);
    return refm.exists(a) ? refm[a] : 32'h0;
  endfunction

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_bus.rvalid <= 1'b0;
      mem_bus.rdata  <= '0;
    end else if (mem_bus.req) begin
      mem_bus.rdata <= ram_rd(mem_bus.addr[31:2]);
      if (mem_bus.we) ram[mem_bus.addr[31:2]] = mem_bus.wdata;
      mem_bus.rvalid <= 1'b1;
    end else begin
      mem_bus.rvalid <= 1'b0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq [$];
  logic [31:0] rq [$];
  int          dq [$];
  logic [31:0] csq [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every bus request and done pulse against the scoreboard queues.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mem_bus.req) begin
        chk("be", 32'(mem_bus.be), 32'hF);
        chk("busy_during_req", 32'(busy), 32'h1);
        if (mem_bus.we) begin
          if (wq.size() == 0) fail_evt("unexpected_write");
          else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", mem_bus.addr, w.addr);
            chk("wr_data", mem_bus.wdata, w.data);
          end
        end else begin
          if (rq.size() == 0) fail_evt("unexpected_read");
          else chk("rd_addr", mem_bus.addr, rq.pop_front());
        end
      end
      if (done) begin
        chk("busy_at_done", 32'(busy), 32'h0);
        chk("req_at_done", 32'(mem_bus.req), 32'h0);
        if (dq.size() == 0) fail_evt("unexpected_done");
        else chk("done_cycle", cyc, dq.pop_front());
        if (csq.size() != 0) begin
`ifdef RAM_1P_DMA_CHECKSUM_EN
          chk("checksum", checksum, csq.pop_front());
`else
          void'(csq.pop_front());
`endif
        end
      end
    end
  end

  // Reference model: words move one at a time in ascending order, read before write.
  task automatic issue(bit md, logic [31:0] s, logic [31:0] d, int n, logic [31:0] f);
    bit [29:0]   sw;
    bit [29:0]   dw;
    logic [31:0] val;
    logic [31:0] cs;
    @(posedge clk_i);
    #1;
    cs = '0;
    for (int i = 0; i < n; i++) begin
      sw  = s[31:2] + 30'(i);
      dw  = d[31:2] + 30'(i);
      val = md ? f : ref_rd(sw);
      if (!md) rq.push_back({sw, 2'b00});
      wq.push_back('{addr: {dw, 2'b00}, data: val});
      refm[dw] = val;
      cs = {cs[30:0], cs[31]} ^ val;
    end
    dq.push_back(cyc + 1 + ((n == 0) ? 0 : (md ? n : 3 * n)));
    csq.push_back(cs);
    start_i = 1'b1;
    mode_i  = md;
    src     = s;
    dst     = d;
    len     = LW'(n);
    fill    = f;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    mode_i  = 1'($urandom);
    src     = $urandom;
    dst     = $urandom;
    len     = LW'($urandom);
    fill    = $urandom;
  endtask

  task automatic wait_idle(int budget);
    for (int i = 0; i < budget && dq.size() != 0; i++) @(posedge clk_i);
    if (dq.size() != 0) begin
      fail_evt("done_timeout");
      wq.delete(); rq.delete(); dq.delete(); csq.delete();
    end
    @(posedge clk_i);
  endtask

  task automatic preload(bit [29:0] a, logic [31:0] v);
    ram[a]  = v;
    refm[a] = v;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap [bit [29:0]];
    logic [31:0] dummy;

    // Reset state
    #23;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_req", 32'(mem_bus.req), 32'h0);
    chk("rst_we", 32'(mem_bus.we), 32'h0);
    chk("rst_addr", mem_bus.addr, 32'h0);
    chk("rst_wdata", mem_bus.wdata, 32'h0);
    chk("rst_be", 32'(mem_bus.be), 32'hF);
`ifdef RAM_1P_DMA_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'h0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed fill
    issue(1'b1, 32'h0, 32'h100, 4, 32'hA5A5A5A5);
    wait_idle(50);

    // Directed copy
    preload(30'h0, 32'h11); preload(30'h1, 32'h22);
    preload(30'h2, 32'h33); preload(30'h3, 32'h44);
    issue(1'b0, 32'h0, 32'h40, 4, 32'h0);
    wait_idle(50);

    // Zero length: no request, no busy
    issue(1'b0, 32'h0, 32'h80, 0, 32'h0);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_req", 32'(mem_bus.req), 32'h0);
    wait_idle(10);

    // Wrap-around with an ignored second start
    issue(1'b1, 32'h0, 32'hFFFFFFF8, 3, 32'h5A5A0001);
    start_i = 1'b1; mode_i = 1'b1; dst = 32'h200; len = LW'(5);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_idle(50);

    // Checksum directed case
    issue(1'b1, 32'h0, 32'h300, 2, 32'h00000001);
    wait_idle(50);

    // Randomized copies and fills over a small, possibly overlapping window
    for (int i = 0; i < 128; i++) preload(30'(i), $urandom);
    for (int t = 0; t < 24; t++) begin
      issue(1'($urandom), {24'h0, 6'($urandom), 2'($urandom)},
            {23'h0, 7'($urandom), 2'($urandom)}, int'($urandom_range(0, 6)), $urandom);
      wait_idle(100);
    end

    // Reset during WAIT of word 2 of an 8-word copy
    for (int i = 0; i < 8; i++) preload(30'h180 + 30'(i), 32'hC0DE0000 + 32'(i));
    snap = refm;
    issue(1'b0, 32'h600, 32'h700, 8, 32'h0);
    repeat (4) @(posedge clk_i);
    #3;
    chk("pre_rst_req", 32'(mem_bus.req), 32'h0);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_bus.req), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_we", 32'(mem_bus.we), 32'h0);
    wq.delete(); rq.delete(); dq.delete(); csq.delete();
    refm = snap;
    dummy = snap[30'h180];
    refm[30'h1C0] = dummy;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    issue(1'b1, 32'h0, 32'h500, 1, 32'hDEADBEEF);
    wait_idle(20);

    // Final memory image and scoreboard drain
    foreach (refm[a]) chk("mem_image", ram_rd(a), refm[a]);
    chk("wq_empty", 32'(wq.size()), 32'h0);
    chk("rq_empty", 32'(rq.size()), 32'h0);
    chk("dq_empty", 32'(dq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
